// File: rtl/spm_arb_pkg.sv
// Shared definitions for the scratchpad port-B arbiter: FSM state codes,
// owner codes, strobe/direction levels and default bus widths.
// Imported by spm_arb and spm_arb_sel.
package spm_arb_pkg;

   // Strobe and direction levels seen on the SPM pins
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;

   // Bus widths of the SPM port
   localparam int SPM_ADDR_W  = 12;
   localparam int WORD_DATA_W = 32;

   // Access sequencer states
   typedef enum logic [1:0] {
      SPM_ARB_IDLE   = 2'd0,
      SPM_ARB_ACCESS = 2'd1,
      SPM_ARB_RESP   = 2'd2
   } spm_arb_state_e;

   // Owner of the access in flight
   localparam logic SPM_ARB_OWNER_M = 1'b0;
   localparam logic SPM_ARB_OWNER_D = 1'b1;

   // Consecutive M grants tolerated while D waits
   localparam int SPM_ARB_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/spm_arb_sel.sv
// Grant decision for the two masters plus the D-starvation counter.
// Ports: i_clk/i_reset_ clock and async active-low reset; i_m_req_/i_d_req_
// active-low requests; i_idle sequencer idle flag; o_grant_vld, o_owner.
module spm_arb_sel
   import spm_arb_pkg::*;
#(
   parameter int MAX_WAIT = SPM_ARB_MAX_WAIT_DEF
) (
   input  logic i_clk,
   input  logic i_reset_,
   input  logic i_m_req_,
   input  logic i_d_req_,
   input  logic i_idle,
   output logic o_grant_vld,
   output logic o_owner
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] r_wait_cnt;
   logic       w_m_req;
   logic       w_d_req;
   logic       w_d_wins;

   assign w_m_req = ~i_m_req_;
   assign w_d_req = ~i_d_req_;

   // M has priority unless D has already been passed over MAX_WAIT times
   assign w_d_wins    = w_d_req & (~w_m_req | (r_wait_cnt == MAX_WAIT_C));
   assign o_grant_vld = i_idle & (w_m_req | w_d_req);
   assign o_owner     = w_d_wins ? SPM_ARB_OWNER_D : SPM_ARB_OWNER_M;

   // Counts M grants taken while D was waiting; only IDLE cycles matter
   always_ff @(posedge i_clk or negedge i_reset_) begin
      if (!i_reset_) begin
         r_wait_cnt <= 4'd0;
      end else if (i_idle) begin
         if (!w_d_req || w_d_wins) begin
            r_wait_cnt <= 4'd0;
         end else if (w_m_req && (r_wait_cnt != MAX_WAIT_C)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/spm_arb.sv
// Shares SPM port B between the MEM stage (M) and a DMA/debug master (D):
// IDLE grants and latches a request, ACCESS strobes the SPM, RESP returns
// data with a one-cycle active-low ready. Ports: clk, reset_ (async, low);
// m_*/d_* master request/response sets; spm_* pins toward the SPM.
module spm_arb
   import spm_arb_pkg::*;
#(
   parameter int ADDR_W   = SPM_ADDR_W,
   parameter int DATA_W   = WORD_DATA_W,
   parameter int MAX_WAIT = SPM_ARB_MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              m_req_,
   input  logic              m_rw,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wr_data,
   output logic [DATA_W-1:0] m_rd_data,
   output logic              m_rdy_,
   input  logic              d_req_,
   input  logic              d_rw,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic [DATA_W-1:0] d_rd_data,
   output logic              d_rdy_,
   output logic [ADDR_W-1:0] spm_addr,
   output logic              spm_as_,
   output logic              spm_rw,
   output logic [DATA_W-1:0] spm_wr_data,
   input  logic [DATA_W-1:0] spm_rd_data
);

   spm_arb_state_e    r_state;
   spm_arb_state_e    w_next_state;
   logic              r_owner;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [DATA_W-1:0] r_m_rd_data;
   logic [DATA_W-1:0] r_d_rd_data;
   logic              w_idle;
   logic              w_grant_vld;
   logic              w_grant_owner;
   logic              w_m_rd_live;
   logic              w_d_rd_live;

   assign w_idle = (r_state == SPM_ARB_IDLE);

   spm_arb_sel #(
      .MAX_WAIT (MAX_WAIT)
   ) u_sel (
      .i_clk       (clk),
      .i_reset_    (reset_),
      .i_m_req_    (m_req_),
      .i_d_req_    (d_req_),
      .i_idle      (w_idle),
      .o_grant_vld (w_grant_vld),
      .o_owner     (w_grant_owner)
   );

   // State register
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state <= SPM_ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: only the IDLE exit depends on inputs
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         SPM_ARB_IDLE:   if (w_grant_vld) w_next_state = SPM_ARB_ACCESS;
         SPM_ARB_ACCESS: w_next_state = SPM_ARB_RESP;
         SPM_ARB_RESP:   w_next_state = SPM_ARB_IDLE;
         default:        w_next_state = SPM_ARB_IDLE;
      endcase
   end

   // Outputs decoded from state so reset forces them inactive at once
   always_comb begin
      spm_as_ = DISABLE_;
      m_rdy_  = 1'b1;
      d_rdy_  = 1'b1;
      case (r_state)
         SPM_ARB_ACCESS: spm_as_ = ENABLE_;
         SPM_ARB_RESP: begin
            if (r_owner == SPM_ARB_OWNER_M) m_rdy_ = 1'b0;
            else                            d_rdy_ = 1'b0;
         end
         default: ;
      endcase
   end

   // Request latch; these registers drive the SPM pins directly
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_owner   <= SPM_ARB_OWNER_M;
         r_rw      <= READ;
         r_addr    <= '0;
         r_wr_data <= '0;
      end else if (w_idle && w_grant_vld) begin
         r_owner <= w_grant_owner;
         if (w_grant_owner == SPM_ARB_OWNER_D) begin
            r_rw      <= d_rw;
            r_addr    <= d_addr;
            r_wr_data <= d_wr_data;
         end else begin
            r_rw      <= m_rw;
            r_addr    <= m_addr;
            r_wr_data <= m_wr_data;
         end
      end
   end

   assign spm_addr    = r_addr;
   assign spm_rw      = r_rw;
   assign spm_wr_data = r_wr_data;

   // SPM data arrives during RESP: pass it through in that cycle so it is
   // valid alongside rdy_, and keep a copy for later cycles
   assign w_m_rd_live = (r_state == SPM_ARB_RESP) && (r_rw == READ) &&
                        (r_owner == SPM_ARB_OWNER_M);
   assign w_d_rd_live = (r_state == SPM_ARB_RESP) && (r_rw == READ) &&
                        (r_owner == SPM_ARB_OWNER_D);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_m_rd_data <= '0;
         r_d_rd_data <= '0;
      end else begin
         if (w_m_rd_live) r_m_rd_data <= spm_rd_data;
         if (w_d_rd_live) r_d_rd_data <= spm_rd_data;
      end
   end

   assign m_rd_data = w_m_rd_live ? spm_rd_data : r_m_rd_data;
   assign d_rd_data = w_d_rd_live ? spm_rd_data : r_d_rd_data;

endmodule

// File: tb/tb_spm_arb.sv
// Self-checking bench for spm_arb: directed vector table, multi-cycle
// arbitration and reset sequences, then random traffic against a
// transaction-level scoreboard with a fairness model.
module tb_spm_arb;
   import spm_arb_pkg::*;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset_;
   logic              req_a  [2];
   logic              rw_a   [2];
   logic [ADDR_W-1:0] addr_a [2];
   logic [DATA_W-1:0] wd_a   [2];
   logic [DATA_W-1:0] m_rd_data, d_rd_data;
   logic              m_rdy_, d_rdy_;
   logic [ADDR_W-1:0] spm_addr;
   logic              spm_as_, spm_rw;
   logic [DATA_W-1:0] spm_wr_data;
   logic [DATA_W-1:0] spm_rd_data;

   always #5 clk = ~clk;

   spm_arb #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .reset_      (reset_),
      .m_req_      (req_a[0]),
      .m_rw        (rw_a[0]),
      .m_addr      (addr_a[0]),
      .m_wr_data   (wd_a[0]),
      .m_rd_data   (m_rd_data),
      .m_rdy_      (m_rdy_),
      .d_req_      (req_a[1]),
      .d_rw        (rw_a[1]),
      .d_addr      (addr_a[1]),
      .d_wr_data   (wd_a[1]),
      .d_rd_data   (d_rd_data),
      .d_rdy_      (d_rdy_),
      .spm_addr    (spm_addr),
      .spm_as_     (spm_as_),
      .spm_rw      (spm_rw),
      .spm_wr_data (spm_wr_data),
      .spm_rd_data (spm_rd_data)
   );

   // Synchronous SPM port-B model: write at the strobe edge, read data
   // valid the cycle after the strobe
   logic              mem_init;
   logic [DATA_W-1:0] mem [0:4095];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
         mem[12'h010] <= 32'hCAFE0001;
      end else if (spm_as_ == ENABLE_) begin
         if (spm_rw == WRITE) mem[spm_addr] <= spm_wr_data;
         spm_rd_data <= mem[spm_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic rdy_of(input int w);
      return (w == 1) ? d_rdy_ : m_rdy_;
   endfunction

   function automatic logic [31:0] rd_of(input int w);
      return (w == 1) ? d_rd_data : m_rd_data;
   endfunction

   // One isolated access; the bus must be idle on entry
   task automatic do_access(input int who, input logic rw,
                            input logic [11:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input int idx);
      @(negedge clk);
      req_a[who] = 1'b0; rw_a[who] = rw; addr_a[who] = addr; wd_a[who] = wd;
      @(negedge clk);
      check($sformatf("vec%0d_strobe", idx), 32'(spm_as_), 32'(ENABLE_));
      check($sformatf("vec%0d_addr", idx), 32'(spm_addr), 32'(addr));
      check($sformatf("vec%0d_rw", idx), 32'(spm_rw), 32'(rw));
      if (rw == WRITE) check($sformatf("vec%0d_wdata", idx), spm_wr_data, wd);
      check($sformatf("vec%0d_rdy_early", idx), {30'd0, m_rdy_, d_rdy_}, 32'd3);
      @(negedge clk);
      check($sformatf("vec%0d_rdy_own", idx), 32'(rdy_of(who)), 32'd0);
      check($sformatf("vec%0d_rdy_other", idx), 32'(rdy_of(1 - who)), 32'd1);
      check($sformatf("vec%0d_rd_data", idx), rd_of(who), exp_rd);
      check($sformatf("vec%0d_strobe_off", idx), 32'(spm_as_), 32'(DISABLE_));
      @(negedge clk);
      req_a[who] = 1'b1;
      check($sformatf("vec%0d_rdy_once", idx), 32'(rdy_of(who)), 32'd1);
   endtask

   typedef struct {
      int          who;
      logic        rw;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [9];

   // Random-phase scoreboard state
   logic [31:0] ref_mem [0:4095];
   logic [31:0] last_rd [2];
   logic        pend [2];
   logic        done [2];
   int          waitc [2];

   task automatic new_req(input int i);
      pend[i]   = 1'b1;
      req_a[i]  = 1'b0;
      rw_a[i]   = 1'($urandom_range(0, 1));
      addr_a[i] = 12'h100 + 12'($urandom_range(0, 15));
      wd_a[i]   = $urandom;
   endtask

   initial begin
      int          m_at, d_at, n;
      int          owners [10];
      int          skips;
      logic        mh0, mh1, dh0, dh1;
      logic        p_as, p_rw;
      logic [11:0] p_addr;
      logic [31:0] p_wd;

      vecs[0] = '{0, READ,  12'h010, 32'h0,        32'hCAFE0001};
      vecs[1] = '{1, WRITE, 12'h3FF, 32'hDEADBEEF, 32'h00000000};
      vecs[2] = '{0, READ,  12'h3FF, 32'h0,        32'hDEADBEEF};
      vecs[3] = '{1, READ,  12'h010, 32'h0,        32'hCAFE0001};
      vecs[4] = '{0, WRITE, 12'h020, 32'h12345678, 32'hDEADBEEF};
      vecs[5] = '{1, READ,  12'h020, 32'h0,        32'h12345678};
      vecs[6] = '{0, READ,  12'h000, 32'h0,        32'h00000000};
      vecs[7] = '{1, WRITE, 12'h010, 32'hA5A5A5A5, 32'h12345678};
      vecs[8] = '{0, READ,  12'h010, 32'h0,        32'hA5A5A5A5};

      for (int i = 0; i < 2; i++) begin
         req_a[i] = 1'b1; rw_a[i] = READ; addr_a[i] = '0; wd_a[i] = '0;
      end
      reset_   = 1'b0;
      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
      check("rst_as", 32'(spm_as_), 32'd1);
      check("rst_rw", 32'(spm_rw), 32'(READ));
      check("rst_addr", 32'(spm_addr), 32'd0);
      check("rst_wdata", spm_wr_data, 32'd0);
      check("rst_m_rd", m_rd_data, 32'd0);
      check("rst_d_rd", d_rd_data, 32'd0);
      check("rst_rdy", {30'd0, m_rdy_, d_rdy_}, 32'd3);
      @(negedge clk);
      reset_ = 1'b1;

      // Directed vector table
      for (int v = 0; v < 9; v++)
         do_access(vecs[v].who, vecs[v].rw, vecs[v].addr, vecs[v].wd,
                   vecs[v].exp_rd, v);

      // Simultaneous first requests: M first, D three cycles later
      @(negedge clk);
      req_a[0] = 1'b0; rw_a[0] = READ; addr_a[0] = 12'h010;
      req_a[1] = 1'b0; rw_a[1] = READ; addr_a[1] = 12'h3FF;
      m_at = -1; d_at = -1;
      for (int c = 1; c <= 20 && (m_at < 0 || d_at < 0); c++) begin
         @(negedge clk);
         if (m_at > 0 && !req_a[0]) req_a[0] = 1'b1;
         if (d_at > 0 && !req_a[1]) req_a[1] = 1'b1;
         if (!m_rdy_) begin
            m_at = c;
            check("sim_m_data", m_rd_data, 32'hA5A5A5A5);
            check("sim_d_idle_rdy", 32'(d_rdy_), 32'd1);
         end
         if (!d_rdy_) begin
            d_at = c;
            check("sim_d_data", d_rd_data, 32'hDEADBEEF);
         end
      end
      check("sim_m_latency", 32'(m_at), 32'd2);
      check("sim_d_latency", 32'(d_at), 32'd5);
      @(negedge clk);
      req_a[0] = 1'b1; req_a[1] = 1'b1;

      // Continuous requests from both: M,M,M,M,D repeating
      @(negedge clk);
      req_a[0] = 1'b0; addr_a[0] = 12'h010;
      req_a[1] = 1'b0; addr_a[1] = 12'h3FF;
      for (int i = 0; i < 10; i++) owners[i] = -1;
      n = 0;
      for (int c = 0; c < 60 && n < 10; c++) begin
         @(negedge clk);
         if (!m_rdy_)      begin owners[n] = 0; n++; end
         else if (!d_rdy_) begin owners[n] = 1; n++; end
      end
      @(negedge clk);
      req_a[0] = 1'b1; req_a[1] = 1'b1;
      for (int i = 0; i < 10; i++)
         check($sformatf("cont_owner%0d", i), 32'(owners[i]),
               (i % 5 == 4) ? 32'd1 : 32'd0);
      repeat (3) @(negedge clk);

      // Reset during the ACCESS cycle of a D read
      @(negedge clk);
      req_a[1] = 1'b0; rw_a[1] = READ; addr_a[1] = 12'h010;
      @(posedge clk);
      #1;
      check("rstmid_in_access", 32'(spm_as_), 32'(ENABLE_));
      reset_ = 1'b0;
      #1;
      check("rstmid_as", 32'(spm_as_), 32'(DISABLE_));
      check("rstmid_d_rdy", 32'(d_rdy_), 32'd1);
      check("rstmid_d_rd", d_rd_data, 32'd0);
      check("rstmid_m_rd", m_rd_data, 32'd0);
      check("rstmid_addr", 32'(spm_addr), 32'd0);
      req_a[1] = 1'b1;
      repeat (2) @(negedge clk);
      reset_ = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rstmid_no_rdy", {30'd0, m_rdy_, d_rdy_}, 32'd3);
      end

      // Random traffic against the scoreboard
      for (int a = 12'h100; a < 12'h110; a++) ref_mem[a] = '0;
      for (int i = 0; i < 2; i++) begin
         last_rd[i] = '0; pend[i] = 1'b0; done[i] = 1'b0; waitc[i] = 0;
      end
      skips = 0;
      mh0 = 1'b1; mh1 = 1'b1; dh0 = 1'b1; dh1 = 1'b1;
      p_as = 1'b1; p_rw = READ; p_addr = '0; p_wd = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rdy_of(i)) begin
               check("rnd_rdy_requested", 32'(pend[i]), 32'd1);
               check("rnd_rdy_excl", 32'(rdy_of(1 - i)), 32'd1);
               check("rnd_strobe", 32'(p_as), 32'(ENABLE_));
               check("rnd_addr", 32'(p_addr), 32'(addr_a[i]));
               check("rnd_rw", 32'(p_rw), 32'(rw_a[i]));
               if (rw_a[i] == WRITE) begin
                  check("rnd_wdata", p_wd, wd_a[i]);
                  ref_mem[addr_a[i]] = wd_a[i];
                  check("rnd_rd_hold", rd_of(i), last_rd[i]);
               end else begin
                  check("rnd_rdata", rd_of(i), ref_mem[addr_a[i]]);
                  last_rd[i] = ref_mem[addr_a[i]];
               end
               // Fairness: M may pass a waiting D at most MAX_WAIT times,
               // and must win whenever D has not used up that allowance
               if (i == 0 && !dh1) begin
                  skips++;
                  check("rnd_fair_bound", 32'(skips <= MAX_WAIT), 32'd1);
               end
               if (i == 1) begin
                  if (!mh1) check("rnd_d_grant_due", 32'(skips), MAX_WAIT);
                  skips = 0;
               end
               done[i]  = 1'b1;
               waitc[i] = 0;
            end else if (done[i]) begin
               done[i] = 1'b0;
               if ($urandom_range(0, 1) == 1) new_req(i);
               else begin pend[i] = 1'b0; req_a[i] = 1'b1; end
            end else if (!pend[i]) begin
               if ($urandom_range(0, 2) == 0) new_req(i);
            end else begin
               waitc[i]++;
               if (waitc[i] == 40) check($sformatf("rnd_timeout%0d", i), 32'd0, 32'd1);
            end
         end
         mh1 = mh0; mh0 = req_a[0];
         dh1 = dh0; dh0 = req_a[1];
         p_as = spm_as_; p_rw = spm_rw; p_addr = spm_addr; p_wd = spm_wr_data;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
